// File: rtl/uart_pkg.sv
// Shared constants, state encodings and helper functions for the buffered UART.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_ARM,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Parity over the active data bits only; odd parity inverts the XOR.
    function automatic logic calc_parity(input logic [7:0] data, input logic [7:0] mask,
                                         input logic odd);
        return (^(data & mask)) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (level != FULL_LEVEL);
    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_ready && out_valid;
    assign push      = in_valid && (in_ready || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo.sv
// Full-duplex UART with TX/RX FIFOs, configurable divisor and 5..8 data bits, parity, 1/2 stops.
// TX and RX engines are independent; RX re-arms on a long idle after reset or a framing error.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        tx,
    input  logic                        rx,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        tx_busy,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overrun
);
    localparam int              DIV       = div(CLK_FREQ, BAUD);
    localparam int              CW        = $clog2(DIV);
    localparam logic [CW-1:0]   DIV_M1    = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF_M1   = CW'(DIV / 2 - 1);
    localparam logic [7:0]      DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic            LAST_STOP = (STOP_BITS == 2);
    localparam logic            ODD       = (PARITY == PAR_ODD);

    if (DIV < 8) begin : g_div_check
        $error("uart_fifo: CLK_FREQ/BAUD must be at least 8");
    end

    logic [7:0] txf_data;
    logic       txf_valid;
    logic       tx_pop;
    logic [7:0] rx_shift;
    logic       rx_push;
    logic       rxf_ready;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_data   (tx_data & DATA_MASK),
        .in_valid  (tx_valid),
        .in_ready  (tx_ready),
        .out_data  (txf_data),
        .out_valid (txf_valid),
        .out_ready (tx_pop),
        .level     (tx_level)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_data   (rx_shift),
        .in_valid  (rx_push),
        .in_ready  (rxf_ready),
        .out_data  (rx_data),
        .out_valid (rx_valid),
        .out_ready (rx_ready),
        .level     (rx_level)
    );

    tx_state_t     tx_state, tx_state_nx;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit_idx;
    logic          tx_stop_idx;
    logic [7:0]    tx_shift;
    logic          tx_par;
    logic          tx_line;
    logic          tx_q;
    logic          tx_tick;

    assign tx_tick = (tx_cnt == '0);
    assign tx      = tx_q;
    assign tx_busy = (tx_state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_nx;
        end
    end

    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            TX_IDLE:   if (txf_valid) tx_state_nx = TX_START;
            TX_START:  if (tx_tick) tx_state_nx = TX_DATA;
            TX_DATA:   if (tx_tick && tx_bit_idx == LAST_BIT)
                           tx_state_nx = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
            TX_PARITY: if (tx_tick) tx_state_nx = TX_STOP;
            TX_STOP:   if (tx_tick && tx_stop_idx == LAST_STOP) tx_state_nx = TX_IDLE;
            default:   tx_state_nx = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pop  = (tx_state == TX_IDLE) && txf_valid;
        tx_line = 1'b1;
        case (tx_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shift[0];
            TX_PARITY: tx_line = tx_par;
            default:   tx_line = 1'b1;
        endcase
    end

    // The line is registered, so it trails the state by one clock with no change to bit widths.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q        <= 1'b1;
            tx_cnt      <= DIV_M1;
            tx_bit_idx  <= '0;
            tx_stop_idx <= 1'b0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
        end else begin
            tx_q   <= tx_line;
            tx_cnt <= (tx_state == TX_IDLE || tx_tick) ? DIV_M1 : tx_cnt - 1'b1;
            if (tx_pop) begin
                tx_shift    <= txf_data;
                tx_par      <= calc_parity(txf_data, DATA_MASK, ODD);
                tx_bit_idx  <= '0;
                tx_stop_idx <= 1'b0;
            end else if (tx_tick) begin
                if (tx_state == TX_DATA) begin
                    tx_shift   <= {1'b0, tx_shift[7:1]};
                    tx_bit_idx <= tx_bit_idx + 3'd1;
                end
                if (tx_state == TX_STOP) begin
                    tx_stop_idx <= tx_stop_idx + 1'b1;
                end
            end
        end
    end

    rx_state_t     rx_state, rx_state_nx;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit_idx;
    logic          rx_stop_idx;
    logic          rx_tick;

    assign rx_tick = (rx_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_ARM;
        end else begin
            rx_state <= rx_state_nx;
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            RX_ARM:    if (rx_s2 && rx_tick) rx_state_nx = RX_IDLE;
            RX_IDLE:   if (rx_prev && !rx_s2) rx_state_nx = RX_START;
            RX_START:  if (rx_tick) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_bit_idx == LAST_BIT)
                           rx_state_nx = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
            RX_PARITY: if (rx_tick) rx_state_nx = RX_STOP;
            RX_STOP:   if (rx_tick) begin
                           if (!rx_s2) rx_state_nx = RX_ARM;
                           else if (rx_stop_idx == LAST_STOP) rx_state_nx = RX_IDLE;
                       end
            default:   rx_state_nx = RX_ARM;
        endcase
    end

    always_comb begin
        rx_push    = (rx_state == RX_STOP) && rx_tick && rx_s2 && (rx_stop_idx == LAST_STOP);
        parity_err = (rx_state == RX_PARITY) && rx_tick &&
                     (rx_s2 != calc_parity(rx_shift, DATA_MASK, ODD));
        frame_err  = (rx_state == RX_STOP) && rx_tick && !rx_s2;
        overrun    = rx_push && !rxf_ready && !(rx_ready && rx_valid);
    end

    // In ARM the counter measures continuous idle; elsewhere it paces mid-bit samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_cnt      <= DIV_M1;
            rx_bit_idx  <= '0;
            rx_stop_idx <= 1'b0;
            rx_shift    <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_state)
                RX_ARM: rx_cnt <= rx_s2 ? rx_cnt - 1'b1 : DIV_M1;
                RX_IDLE: begin
                    rx_cnt      <= HALF_M1;
                    rx_bit_idx  <= '0;
                    rx_stop_idx <= 1'b0;
                    rx_shift    <= '0;
                end
                default: begin
                    rx_cnt <= rx_tick ? DIV_M1 : rx_cnt - 1'b1;
                    if (rx_tick && rx_state == RX_DATA) begin
                        rx_shift[rx_bit_idx] <= rx_s2;
                        rx_bit_idx           <= rx_bit_idx + 3'd1;
                    end
                    if (rx_tick && rx_state == RX_STOP) begin
                        rx_stop_idx <= rx_stop_idx + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: 8N1 TX/RX with a 4-deep FIFO, 7O2 loopback, 8E1 parity errors.
// All instances run at DIV = 10 (1 MHz clock, 100 kbaud).
module tb_uart_fifo;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [7:0] tx_data_a, rx_data_a;
    logic       tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, tx_a, rx_a, tx_busy_a;
    logic       parity_err_a, frame_err_a, overrun_a;
    logic [2:0] tx_level_a, rx_level_a;

    logic [7:0] tx_data_b, rx_data_b;
    logic       tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, tx_b, tx_busy_b;
    logic       parity_err_b, frame_err_b, overrun_b;
    logic [4:0] tx_level_b, rx_level_b;

    logic [7:0] tx_data_c, rx_data_c;
    logic       tx_valid_c, tx_ready_c, rx_valid_c, rx_ready_c, tx_c, rx_c, tx_busy_c;
    logic       parity_err_c, frame_err_c, overrun_c;
    logic [4:0] tx_level_c, rx_level_c;

    uart_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .tx(tx_a), .rx(rx_a),
        .tx_level(tx_level_a), .rx_level(rx_level_a), .tx_busy(tx_busy_a),
        .parity_err(parity_err_a), .frame_err(frame_err_a), .overrun(overrun_a)
    );

    uart_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .tx(tx_b), .rx(tx_b),
        .tx_level(tx_level_b), .rx_level(rx_level_b), .tx_busy(tx_busy_b),
        .parity_err(parity_err_b), .frame_err(frame_err_b), .overrun(overrun_b)
    );

    uart_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                .STOP_BITS(1), .FIFO_DEPTH(16)) dut_c (
        .clk(clk), .rst(rst), .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c),
        .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(rx_ready_c), .tx(tx_c), .rx(rx_c),
        .tx_level(tx_level_c), .rx_level(rx_level_c), .tx_busy(tx_busy_c),
        .parity_err(parity_err_c), .frame_err(frame_err_c), .overrun(overrun_c)
    );

    int tests    = 0;
    int failures = 0;
    int perr_a = 0, ferr_a = 0, ovr_a = 0;
    int perr_b = 0, ferr_b = 0, ovr_b = 0;
    int perr_c = 0, ferr_c = 0, ovr_c = 0;
    int busy_cnt;
    logic       tx_hist [0:127];
    logic [7:0] pat;
    logic [15:0] frame;

    // Error pulses are one clock wide, so counting them once per cycle gives the pulse count.
    always @(negedge clk) begin
        if (parity_err_a) perr_a++;
        if (frame_err_a)  ferr_a++;
        if (overrun_a)    ovr_a++;
        if (parity_err_b) perr_b++;
        if (frame_err_b)  ferr_b++;
        if (overrun_b)    ovr_b++;
        if (parity_err_c) perr_c++;
        if (frame_err_c)  ferr_c++;
        if (overrun_c)    ovr_c++;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives the frame LSB first, one bit per DIV clocks, then returns the line to idle.
    task automatic send_serial(input int which, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (which == 0) rx_a = bits[i];
            else            rx_c = bits[i];
            repeat (DIV) @(negedge clk);
        end
        if (which == 0) rx_a = 1'b1;
        else            rx_c = 1'b1;
    endtask

    initial begin
        tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b0; rx_a = 1'b1;
        tx_data_b = '0; tx_valid_b = 1'b0; rx_ready_b = 1'b0;
        tx_data_c = '0; tx_valid_c = 1'b0; rx_ready_c = 1'b0; rx_c = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset tx_a", tx_a, 1);
        check("reset tx_ready_a", tx_ready_a, 1);
        check("reset rx_valid_a", rx_valid_a, 0);
        check("reset rx_data_a", rx_data_a, 0);
        check("reset tx_level_a", tx_level_a, 0);
        check("reset rx_level_a", rx_level_a, 0);
        check("reset tx_busy_a", tx_busy_a, 0);
        check("reset pulses_a", {parity_err_a, frame_err_a, overrun_a}, 0);
        check("reset tx_b tx_c", {tx_b, tx_c, tx_ready_b, tx_ready_c}, 4'hF);
        check("reset busy/valid b c", {tx_busy_b, tx_busy_c, rx_valid_b, rx_valid_c}, 0);
        check("reset levels b c", {tx_level_b, rx_level_b, tx_level_c, rx_level_c}, 0);

        // 8N1 transmit of 0xA5: handshake edge k, line low after edge k+2
        pat = 8'hA5;
        tx_data_a = pat; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        check("tx_level after write", tx_level_a, 1);
        busy_cnt = 0;
        for (int j = 1; j <= 120; j++) begin
            @(negedge clk);
            tx_hist[j] = tx_a;
            if (tx_busy_a) busy_cnt++;
        end
        check("tx idle at k+1", tx_hist[1], 1);
        check("start first clk", tx_hist[2], 0);
        check("start last clk", tx_hist[11], 0);
        for (int b = 0; b < 8; b++) begin
            check($sformatf("data bit %0d first clk", b), tx_hist[12 + 10 * b], pat[b]);
            check($sformatf("data bit %0d last clk", b), tx_hist[21 + 10 * b], pat[b]);
        end
        check("stop first clk", tx_hist[92], 1);
        check("stop last clk", tx_hist[101], 1);
        check("tx_busy length 8N1", busy_cnt, 100);

        // 7O2 loopback; bit 7 of the written byte must be ignored
        tx_data_b = 8'hC1; tx_valid_b = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b0;
        busy_cnt = 0;
        for (int j = 0; j < 160; j++) begin
            @(negedge clk);
            if (tx_busy_b) busy_cnt++;
        end
        check("tx_busy length 7O2", busy_cnt, 110);
        check("loopback rx_valid", rx_valid_b, 1);
        check("loopback rx_data", rx_data_b, 8'h41);
        check("loopback rx_level", rx_level_b, 1);
        check("loopback errors", perr_b + ferr_b + ovr_b, 0);
        rx_ready_b = 1'b1;
        @(negedge clk);
        rx_ready_b = 1'b0;
        check("loopback popped", rx_valid_b, 0);

        // 8E1: 0x03 with parity bit 1 is wrong, 0x07 with parity bit 1 is right
        frame = {5'b0, 1'b1, 1'b1, 8'h03, 1'b0};
        send_serial(2, frame, 11);
        check("parity_err count bad", perr_c, 1);
        check("parity bad byte pushed", rx_data_c, 8'h03);
        check("parity bad rx_level", rx_level_c, 1);
        rx_ready_c = 1'b1;
        @(negedge clk);
        rx_ready_c = 1'b0;
        frame = {5'b0, 1'b1, 1'b1, 8'h07, 1'b0};
        send_serial(2, frame, 11);
        check("parity_err count good", perr_c, 1);
        check("parity good byte", rx_data_c, 8'h07);
        check("parity frame_err", ferr_c + ovr_c, 0);

        // 8N1 frame with stop bit low, then a good frame after re-arming
        frame = {6'b0, 1'b0, 8'h55, 1'b0};
        send_serial(0, frame, 10);
        check("frame_err count", ferr_a, 1);
        check("frame_err rx_level", rx_level_a, 0);
        repeat (14) @(negedge clk);
        frame = {6'b0, 1'b1, 8'h12, 1'b0};
        send_serial(0, frame, 10);
        check("after rearm rx_level", rx_level_a, 1);
        check("after rearm rx_data", rx_data_a, 8'h12);
        check("after rearm frame_err", ferr_a, 1);
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;

        // Five bytes into a 4-deep RX FIFO with no pops
        for (int v = 1; v <= 5; v++) begin
            frame = {6'b0, 1'b1, 8'(v), 1'b0};
            send_serial(0, frame, 10);
            repeat (2) @(negedge clk);
            if (v == 4) begin
                check("no overrun at byte 4", ovr_a, 0);
                check("rx_level full", rx_level_a, 4);
            end
        end
        check("overrun on byte 5", ovr_a, 1);
        check("rx_level after overrun", rx_level_a, 4);
        for (int v = 1; v <= 4; v++) begin
            check($sformatf("pop %0d", v), rx_data_a, v);
            rx_ready_a = 1'b1;
            @(negedge clk);
            rx_ready_a = 1'b0;
        end
        check("rx empty after pops", {rx_valid_a, rx_level_a}, 0);

        // Two 0xFF writes, reset at clock 35 of the first frame
        tx_data_a = 8'hFF; tx_valid_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (33) @(negedge clk);
        check("mid-frame busy", tx_busy_a, 1);
        check("mid-frame tx_level", tx_level_a, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post-reset tx", tx_a, 1);
        check("post-reset tx_level", tx_level_a, 0);
        check("post-reset tx_busy", tx_busy_a, 0);
        repeat (20) @(negedge clk);
        check("post-reset quiet", {tx_a, tx_busy_a}, 2'b10);

        // 3-clock low glitch on an armed, idle receiver is a false start
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch no push", {rx_valid_a, rx_level_a}, 0);
        check("glitch no errors", {perr_a, ferr_a, ovr_a}, {32'd0, 32'd1, 32'd1});

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Parametrised full-duplex UART with configurable baud divisor, frame format (5–8 data bits, optional even/odd parity, 1 or 2 stop bits) and TX/RX FIFOs.
- Replaces the fixed 8N1 unbuffered UART.
- Sits between the lock controller and the serial pins.
- Adds valid/ready streaming, buffering, and per-frame error reporting.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- BAUD, 9600, line rate; DIV = CLK_FREQ/BAUD (integer division); elaboration error if DIV < 8.
- DATA_BITS, 8, 5..8 data bits, LSB first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 16, entries per FIFO; power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send; bits above DATA_BITS-1 ignored.
- tx_valid  in  1  write request.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  8  head of RX FIFO, zero-extended above DATA_BITS.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pop request.
- tx  out  1  serial out, idle high.
- rx  in  1  serial in, asynchronous.
- tx_level  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
- rx_level  out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- tx_busy  out  1  TX engine not in IDLE.
- parity_err  out  1  one-cycle pulse.
- frame_err  out  1  one-cycle pulse.
- overrun  out  1  one-cycle pulse.

Behaviour:
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, both levels=0, tx_busy=0, all error pulses=0.
- Reset mid-frame: both FIFOs are emptied and both frames abort on the same edge; tx is driven high from the next cycle.
- FIFOs: synchronous, first-word fall-through.
  - Write when valid&&ready; read when valid&&ready.
  - Simultaneous push and pop on a full FIFO are both accepted; level is unchanged.
  - Pop on empty and push on full are ignored.
- TX engine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the TX FIFO is non-empty, pop the head and latch it into the shift register.
  - Handshake on edge k → tx low after edge k+2.
  - Each state lasts exactly DIV clocks, counted by a baud counter that reloads on every state/bit change.
  - DATA shifts DATA_BITS bits, LSB first.
  - PARITY is skipped when PARITY = 0. Parity bit = XOR of the data bits, inverted for odd parity.
  - STOP holds tx high for STOP_BITS×DIV clocks, then returns to IDLE.
  - Back-to-back bytes: no idle gap beyond one clock between the last stop bit and the next start bit.
- RX engine states: ARM, IDLE, START, DATA, PARITY, STOP.
  - rx passes through a 2-flop synchroniser whose flops reset to 1.
  - ARM (entered after reset): wait for the synchronised rx to be high for DIV consecutive clocks, then go to IDLE.
  - IDLE: a falling edge on synchronised rx enters START.
  - START: sample at DIV/2. If rx is high, it is a false start → back to IDLE, nothing reported.
  - Subsequent samples are taken every DIV clocks, at mid-bit.
  - Parity mismatch: pulse parity_err; the byte is still pushed.
  - Any stop bit sampled low: pulse frame_err, discard the byte, go to ARM.
  - Good frame: push on the stop-bit sample cycle.
  - If the RX FIFO is full and no pop occurs that cycle: drop the byte and pulse overrun.
  - Pulses are asserted on the sample cycle of the offending bit.
- The TX and RX engines are fully independent; loopback (tx tied to rx) must work.

Decomposition:
- uart_pkg holds:
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - TX and RX state encodings;
  - a divisor function div(clk, baud);
  - a parity function over an 8-bit word with a DATA_BITS mask.
- One natural sub-module: uart_sync_fifo (parameters WIDTH, DEPTH; first-word fall-through; level output), instantiated twice.
- The TX and RX engines stay inline as two always-block groups.

Test Plan:
All scenarios use CLK_FREQ=1_000_000 and BAUD=100_000 (DIV=10).
- 8N1, write 0xA5 → tx after edge k+2: 0 for 10 clk; then bits 1,0,1,0,0,1,0,1 at 10 clk each; then 1. tx_busy is high for exactly 100 clk.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, loopback, send 0x41 → rx_data=0x41, no error pulses, frame length 110 clk.
- PARITY=1, inject frame 0x03 with parity bit 1 → parity_err pulses once; rx_data=0x03 pushed.
- Inject 0x55 with stop bit 0 → frame_err pulses; rx_level stays 0; the next valid frame 0x12 is received after rx is high for 10 clk.
- FIFO_DEPTH=4, rx_ready=0, receive 5 bytes 0x01..0x05 → rx_level=4, overrun pulses on byte 5, pops return 0x01..0x04.
- Write 0xFF, assert rst at clk 35 of the frame → tx=1 next cycle, tx_level=0; 3-clk low glitch on rx → no push, no errors.
